// File: rtl/proc_mem.sv
// Multicycle 16-bit processor, r7 is the PC, fetches from external sync memory.
// Ports: Clock/Resetn, Run start, DIN read data, ADDR/DOUT/W memory bus, Done.
module proc_mem #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [15:0]       DIN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       DOUT,
  output logic              W,
  output logic              Done
);

  typedef enum logic [2:0] {F0, F1, F2, E1, E2, E3} state_t;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  state_t state_q, state_d;
  logic [15:0] r_q [8];
  logic [15:0] r_d [8];
  logic [15:0] a_q, a_d, g_q, g_d, ir_q, ir_d;
  logic [15:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic z_q, z_d, n_q, n_d, c_q, c_d, w_q, w_d;

  logic [2:0]  op, rx, ry;
  logic        m, cond_ok;
  logic [15:0] dext, d8, opnd;
  logic [16:0] sum;

  assign op   = ir_q[15:13];
  assign m    = ir_q[12];
  assign rx   = ir_q[11:9];
  assign ry   = ir_q[2:0];
  assign dext = {{7{ir_q[8]}}, ir_q[8:0]};
  assign d8   = {ir_q[7:0], 8'h00};
  assign opnd = m ? dext : r_q[ry];

  assign ADDR = addr_q;
  assign DOUT = dout_q;
  assign W    = w_q;

  always_comb begin
    cond_ok = 1'b0;
    case (rx)
      3'd0: cond_ok = 1'b1;
      3'd1: cond_ok = z_q;
      3'd2: cond_ok = !z_q;
      3'd3: cond_ok = !c_q;
      3'd4: cond_ok = c_q;
      3'd5: cond_ok = !n_q;
      3'd6: cond_ok = n_q;
      default: cond_ok = 1'b0;
    endcase
  end

  // sub carry is carry-out of A + ~B + 1, so C=1 means no borrow
  always_comb begin
    sum = '0;
    case (op)
      OP_ADD: sum = {1'b0, a_q} + {1'b0, opnd};
      OP_SUB: sum = {1'b0, a_q} + {1'b0, ~opnd} + 17'd1;
      OP_AND: sum = {1'b0, a_q & opnd};
      default: sum = '0;
    endcase
  end

  always_comb begin
    Done = 1'b0;
    unique case (state_q)
      E1: Done = (op == OP_MV) || (op == OP_NOP) ||
                 (op == OP_BR && (m || !cond_ok));
      E2: Done = (op == OP_ST);
      E3: Done = 1'b1;
      default: Done = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    g_d     = g_q;
    ir_d    = ir_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    w_d     = 1'b0;
    unique case (state_q)
      F0: begin
        if (Run) begin
          addr_d  = r_q[7][ADDR_W-1:0];
          r_d[7]  = r_q[7] + 16'd1;
          state_d = F1;
        end
      end
      F1: state_d = F2;
      F2: begin
        ir_d    = DIN;
        state_d = E1;
        // store bus is loaded with IR so W is high exactly during E1
        if (DIN[15:13] == OP_ST) begin
          addr_d = r_q[DIN[2:0]][ADDR_W-1:0];
          dout_d = r_q[DIN[11:9]];
          w_d    = 1'b1;
        end
      end
      E1: begin
        case (op)
          OP_MV: r_d[rx] = opnd;
          OP_BR: begin
            if (m) r_d[rx] = d8;
            else if (cond_ok) a_d = r_q[7];
          end
          OP_ADD, OP_SUB, OP_AND: a_d = r_q[rx];
          OP_LD: addr_d = r_q[ry][ADDR_W-1:0];
          default: ;
        endcase
        state_d = Done ? F0 : E2;
      end
      E2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            g_d = sum[15:0];
            z_d = (sum[15:0] == 16'h0000);
            n_d = sum[15];
            if (op != OP_AND) c_d = sum[16];
          end
          OP_BR: g_d = a_q + dext;
          default: ;
        endcase
        state_d = Done ? F0 : E3;
      end
      E3: begin
        if (op == OP_BR) r_d[7] = g_q;
        else if (op == OP_LD) r_d[rx] = DIN;
        else r_d[rx] = g_q;
        state_d = F0;
      end
      default: state_d = F0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= F0;
      for (int i = 0; i < 7; i++) r_q[i] <= '0;
      r_q[7] <= RESET_PC;
      a_q    <= '0;
      g_q    <= '0;
      ir_q   <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      g_q     <= g_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_proc_mem.sv
// Bench for proc_mem: ISA-level reference model, expected-event scoreboard.
// Checks fetch address, latency, store bus and reset behaviour.
module tb_proc_mem;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] DIN = '0;
  logic [15:0] ADDR, DOUT;
  logic        W, Done;
  logic [7:0]  addr2;
  logic [15:0] dout2, din2;
  logic        w2, done2;

  assign din2 = 16'hE000;

  proc_mem dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
    .ADDR(ADDR), .DOUT(DOUT), .W(W), .Done(Done)
  );

  proc_mem #(.ADDR_W(8), .RESET_PC(16'h0020)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(din2),
    .ADDR(addr2), .DOUT(dout2), .W(w2), .Done(done2)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] pc;
    int          lat;
    bit          st;
    logic [15:0] sa;
    logic [15:0] sd;
  } exp_t;

  bit   [15:0] mem [0:65535];
  bit   [15:0] mm  [0:65535];
  logic [15:0] mr  [0:7];
  bit          mz, mn, mc;
  bit          poke_en = 1'b0;
  logic [15:0] poke_addr = '0, poke_data = '0;
  exp_t        q[$];
  logic [15:0] dir[$];
  int          ncmp = 0, nerr = 0, done_cnt = 0;
  bit          mon_en = 1'b0, chk2 = 1'b1;
  int          cyc = 0, wcnt = 0;
  logic [15:0] fa, wa, wd;

  always @(posedge Clock) begin
    DIN <= mem[ADDR];
    if (W) mem[ADDR] = DOUT;
    if (poke_en) mem[poke_addr] = poke_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                      input logic [2:0] x,
                                      input logic [8:0] d);
    return {op, m, x, d};
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = v;
    mm[a]     = v;
    @(posedge Clock);
    #1;
    poke_en = 1'b0;
  endtask

  // instruction-level model: one call = one architectural instruction
  task automatic model_exec(input logic [15:0] ins, output exp_t e);
    logic [2:0] op, x, y;
    logic       m;
    logic [15:0] d, a, b, res;
    int unsigned tot;
    bit tk;
    op = ins[15:13]; m = ins[12]; x = ins[11:9]; y = ins[2:0];
    d  = {{7{ins[8]}}, ins[8:0]};
    e.pc = mr[7]; e.lat = 4; e.st = 0; e.sa = 0; e.sd = 0;
    mr[7] = mr[7] + 16'd1;
    tk = 0;
    case (op)
      3'd0: mr[x] = m ? d : mr[y];
      3'd1: begin
        if (m) mr[x] = {ins[7:0], 8'h00};
        else begin
          case (x)
            3'd0: tk = 1;
            3'd1: tk = mz;
            3'd2: tk = !mz;
            3'd3: tk = !mc;
            3'd4: tk = mc;
            3'd5: tk = !mn;
            3'd6: tk = mn;
            default: tk = 0;
          endcase
          if (tk) begin
            mr[7] = mr[7] + d;
            e.lat = 6;
          end
        end
      end
      3'd2, 3'd3, 3'd6: begin
        a = mr[x];
        b = m ? d : mr[y];
        if (op == 3'd2) begin
          tot = int'(a) + int'(b);
          res = tot[15:0];
          mc  = (tot > 65535);
        end else if (op == 3'd3) begin
          res = a - b;
          mc  = (a >= b);
        end else begin
          res = a & b;
        end
        mz = (res == 0);
        mn = res[15];
        mr[x] = res;
        e.lat = 6;
      end
      3'd4: begin
        mr[x] = mm[mr[y]];
        e.lat = 6;
      end
      3'd5: begin
        e.st = 1; e.sa = mr[y]; e.sd = mr[x];
        mm[mr[y]] = mr[x];
        e.lat = 5;
      end
      default: ;
    endcase
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (!mon_en) begin
      cyc = 0;
      wcnt = 0;
    end else begin
      cyc++;
      if (cyc == 2) fa = ADDR;
      if (cyc == 2 && chk2) begin
        chk("reset_pc_fetch2", {24'h0, addr2}, 32'h20);
        chk2 = 0;
      end
      if (W) begin
        wcnt++;
        wa = ADDR;
        wd = DOUT;
      end
      if (Done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("fetch_addr", {16'h0, fa}, {16'h0, e.pc});
          chk("latency", cyc, e.lat);
          chk("w_cycles", wcnt, {31'h0, e.st});
          if (e.st) begin
            chk("st_addr", {16'h0, wa}, {16'h0, e.sa});
            chk("st_data", {16'h0, wd}, {16'h0, e.sd});
          end
        end
        done_cnt++;
        cyc = 0;
        wcnt = 0;
      end
    end
  end

  // entered with Resetn low, at posedge+1; leaves Run low, monitor off
  task automatic run_prog(input int nrand);
    exp_t e;
    logic [15:0] ins;
    int base, t;
    for (int i = 0; i < 7; i++) mr[i] = 0;
    mr[7] = 0;
    mz = 0; mn = 0; mc = 0;
    q.delete();
    for (int k = 0; k < dir.size() + nrand; k++) begin
      ins = (k < dir.size()) ? dir[k] : 16'($urandom);
      poke(mr[7], ins);
      model_exec(ins, e);
      q.push_back(e);
      if (k == 0) begin
        Resetn = 1;
        Run = 1;
        mon_en = 1;
      end
      base = done_cnt;
      t = 0;
      while (t < 12 && done_cnt == base) begin
        @(posedge Clock);
        t++;
      end
      #1;
      if (done_cnt == base) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    Run = 0;
    mon_en = 0;
  endtask

  initial begin
    logic [15:0] a0;
    int dn, wn;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_addr", {16'h0, ADDR}, 0);
    chk("rst_dout", {16'h0, DOUT}, 0);
    chk("rst_w", {31'h0, W}, 0);
    chk("rst_done", {31'h0, Done}, 0);

    dir.push_back(enc(3'd0, 1, 3'd0, 9'h005));
    dir.push_back(enc(3'd1, 1, 3'd1, 9'h012));
    dir.push_back(enc(3'd0, 1, 3'd2, 9'h1FF));
    dir.push_back(enc(3'd2, 1, 3'd2, 9'h001));
    dir.push_back(enc(3'd1, 0, 3'd1, 9'h1FD));
    dir.push_back(enc(3'd3, 1, 3'd2, 9'h001));
    dir.push_back(enc(3'd1, 0, 3'd1, 9'h1FD));
    dir.push_back(enc(3'd1, 0, 3'd6, 9'h003));
    dir.push_back(enc(3'd0, 1, 3'd3, 9'h040));
    dir.push_back(enc(3'd1, 1, 3'd4, 9'h0BE));
    dir.push_back(enc(3'd2, 1, 3'd4, 9'h0EF));
    dir.push_back(enc(3'd5, 0, 3'd4, 9'h003));
    dir.push_back(enc(3'd4, 0, 3'd5, 9'h003));
    dir.push_back(enc(3'd5, 0, 3'd5, 9'h000));
    dir.push_back(enc(3'd0, 1, 3'd7, 9'h1FF));
    dir.push_back(enc(3'd0, 0, 3'd6, 9'h002));
    dir.push_back(enc(3'd5, 0, 3'd6, 9'h000));
    dir.push_back(enc(3'd6, 0, 3'd4, 9'h002));
    dir.push_back(16'hE000);
    run_prog(300);

    a0 = ADDR;
    dn = 0;
    wn = 0;
    repeat (10) begin
      @(posedge Clock);
      #1;
      dn += int'(Done);
      wn += int'(W);
    end
    chk("idle_addr", {16'h0, ADDR}, {16'h0, a0});
    chk("idle_done", dn, 0);
    chk("idle_w", wn, 0);

    Resetn = 0;
    repeat (2) @(posedge Clock);
    #1;
    poke(16'h0000, enc(3'd5, 0, 3'd1, 9'h002));
    Resetn = 1;
    Run = 1;
    repeat (3) @(posedge Clock);
    #1;
    chk("st_e1_w", {31'h0, W}, 1);
    Resetn = 0;
    Run = 0;
    @(posedge Clock);
    #1;
    chk("rst_st_w", {31'h0, W}, 0);
    chk("rst_st_done", {31'h0, Done}, 0);
    chk("rst_st_addr", {16'h0, ADDR}, 0);

    poke(16'h0000, enc(3'd2, 1, 3'd1, 9'h005));
    Resetn = 1;
    Run = 1;
    repeat (4) @(posedge Clock);
    #1;
    Resetn = 0;
    Run = 0;
    @(posedge Clock);
    #1;
    chk("rst_add_done", {31'h0, Done}, 0);
    chk("rst_add_w", {31'h0, W}, 0);
    chk("rst_add_addr", {16'h0, ADDR}, 0);

    dir.delete();
    dir.push_back(enc(3'd5, 0, 3'd1, 9'h000));
    dir.push_back(enc(3'd0, 1, 3'd7, 9'h1FF));
    dir.push_back(16'hE000);
    run_prog(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             ncmp, nerr);
    $finish;
  end

endmodule
